// File: rtl/mem_stage.sv
// Pipeline MEM stage: drives one outstanding data-memory access and loads the MEM/WB register.
// Latency: 1 cycle for non-memory ops; 3 cycles per memory op with a same-cycle ack (IDLE, REQ, DONE).
// Backpressure: Stall_o freezes upstream while an access is pending; aborts after TIMEOUT cycles in REQ.
//
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-low reset
//   RegWrite_i..RDaddr_i            EX/MEM control, address/result, store data, destination register
//   MemReq_o..MemWdata_o            data-memory request (held stable until MemAck_i)
//   MemAck_i, MemRdata_i            one-cycle completion, read data valid with the ack
//   RegWrite_o..RDaddr_o            MEM/WB register outputs
//   Stall_o, Err_o                  upstream freeze, one-cycle misalignment/timeout error pulse
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] RS2data_i,
    input  logic [4:0]  RDaddr_i,
    output logic        MemReq_o,
    output logic        MemWe_o,
    output logic [31:0] MemAddr_o,
    output logic [31:0] MemWdata_o,
    input  logic        MemAck_i,
    input  logic [31:0] MemRdata_i,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic [31:0] ALUResult_o,
    output logic [31:0] MemData_o,
    output logic [4:0]  RDaddr_o,
    output logic        Stall_o,
    output logic        Err_o
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state;
    state_t      next_state;
    logic [4:0]  cnt;
    logic [31:0] rd_buf;
    logic        aborted;
    logic        stall;

    logic memop;
    logic aligned;
    logic timed_out;

    // A write with MemRead_i also set is still a write: MemWe_o follows MemWrite_i.
    assign memop     = MemRead_i | MemWrite_i;
    assign aligned   = (ALUResult_i[1:0] == 2'b00);
    assign timed_out = (cnt == 5'(TIMEOUT - 1));

    // Gated by reset so the stall drops immediately even if upstream still presents a memop.
    assign Stall_o = rst_i & stall;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (memop && aligned) begin
                    stall      = 1'b1;
                    next_state = REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                // Ack is checked first so an ack coinciding with the timeout completes normally.
                if (MemAck_i || timed_out) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            MemReq_o    <= 1'b0;
            MemWe_o     <= 1'b0;
            MemAddr_o   <= '0;
            MemWdata_o  <= '0;
            RegWrite_o  <= 1'b0;
            MemtoReg_o  <= 1'b0;
            ALUResult_o <= '0;
            MemData_o   <= '0;
            RDaddr_o    <= '0;
            Err_o       <= 1'b0;
            cnt         <= '0;
            rd_buf      <= '0;
            aborted     <= 1'b0;
        end else begin
            Err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (memop) begin
                        // Bubble into MEM/WB; remaining fields hold their last value.
                        RegWrite_o <= 1'b0;
                        MemtoReg_o <= 1'b0;
                        if (aligned) begin
                            MemReq_o   <= 1'b1;
                            MemWe_o    <= MemWrite_i;
                            MemAddr_o  <= ALUResult_i;
                            MemWdata_o <= RS2data_i;
                            cnt        <= '0;
                            aborted    <= 1'b0;
                        end else begin
                            Err_o <= 1'b1;
                        end
                    end else begin
                        RegWrite_o  <= RegWrite_i;
                        MemtoReg_o  <= MemtoReg_i;
                        ALUResult_o <= ALUResult_i;
                        RDaddr_o    <= RDaddr_i;
                    end
                end
                REQ: begin
                    RegWrite_o <= 1'b0;
                    MemtoReg_o <= 1'b0;
                    if (cnt != 5'h1f) begin
                        cnt <= cnt + 5'd1;
                    end
                    if (MemAck_i) begin
                        MemReq_o <= 1'b0;
                        if (!MemWe_o) begin
                            rd_buf <= MemRdata_i;
                        end
                    end else if (timed_out) begin
                        MemReq_o <= 1'b0;
                        aborted  <= 1'b1;
                    end
                end
                DONE: begin
                    aborted <= 1'b0;
                    if (aborted) begin
                        RegWrite_o <= 1'b0;
                        MemtoReg_o <= 1'b0;
                        Err_o      <= 1'b1;
                    end else begin
                        RegWrite_o  <= RegWrite_i;
                        MemtoReg_o  <= MemtoReg_i;
                        ALUResult_o <= ALUResult_i;
                        RDaddr_o    <= RDaddr_i;
                        MemData_o   <= rd_buf;
                    end
                end
                default: begin
                    MemReq_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk_i;
    logic        rst_i;
    logic        RegWrite_i;
    logic        MemtoReg_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] ALUResult_i;
    logic [31:0] RS2data_i;
    logic [4:0]  RDaddr_i;
    logic        MemReq_o;
    logic        MemWe_o;
    logic [31:0] MemAddr_o;
    logic [31:0] MemWdata_o;
    logic        MemAck_i;
    logic [31:0] MemRdata_i;
    logic        RegWrite_o;
    logic        MemtoReg_o;
    logic [31:0] ALUResult_o;
    logic [31:0] MemData_o;
    logic [4:0]  RDaddr_o;
    logic        Stall_o;
    logic        Err_o;

    int checks;
    int errors;
    int stall_cnt;
    int req_cycles;

    mem_stage #(.TIMEOUT(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .RegWrite_i  (RegWrite_i),
        .MemtoReg_i  (MemtoReg_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .ALUResult_i (ALUResult_i),
        .RS2data_i   (RS2data_i),
        .RDaddr_i    (RDaddr_i),
        .MemReq_o    (MemReq_o),
        .MemWe_o     (MemWe_o),
        .MemAddr_o   (MemAddr_o),
        .MemWdata_o  (MemWdata_o),
        .MemAck_i    (MemAck_i),
        .MemRdata_i  (MemRdata_i),
        .RegWrite_o  (RegWrite_o),
        .MemtoReg_o  (MemtoReg_o),
        .ALUResult_o (ALUResult_o),
        .MemData_o   (MemData_o),
        .RDaddr_o    (RDaddr_o),
        .Stall_o     (Stall_o),
        .Err_o       (Err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; Stall_o is tallied mid-cycle, outputs are then read 1 time unit after the edge.
    task automatic cyc();
        @(negedge clk_i);
        if (Stall_o === 1'b1) stall_cnt++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic rw, input logic mtr, input logic rd, input logic wr,
                         input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rda);
        RegWrite_i  = rw;
        MemtoReg_i  = mtr;
        MemRead_i   = rd;
        MemWrite_i  = wr;
        ALUResult_i = alu;
        RS2data_i   = rs2;
        RDaddr_i    = rda;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        stall_cnt = 0;
        rst_i = 1'b0;
        MemAck_i = 1'b0;
        MemRdata_i = '0;
        // Memop present during reset: Stall_o must still read 0.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd1);
        #3;
        chk("rst_memreq", MemReq_o, 32'd0);
        chk("rst_stall", Stall_o, 32'd0);
        chk("rst_regwrite", RegWrite_o, 32'd0);
        chk("rst_memdata", MemData_o, 32'd0);
        chk("rst_err", Err_o, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #9;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Non-memop, latency 1
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 5'd5);
        #1;
        chk("nm_stall", Stall_o, 32'd0);
        cyc();
        chk("nm_regwrite", RegWrite_o, 32'd1);
        chk("nm_alu", ALUResult_o, 32'h10);
        chk("nm_rd", RDaddr_o, 32'd5);
        chk("nm_memreq", MemReq_o, 32'd0);

        // Load, ack two cycles after MemReq_o rises
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd3);
        stall_cnt = 0;
        #1;
        chk("ld_stall_idle", Stall_o, 32'd1);
        cyc();
        chk("ld_memreq", MemReq_o, 32'd1);
        chk("ld_we", MemWe_o, 32'd0);
        chk("ld_addr", MemAddr_o, 32'h100);
        chk("ld_bubble", RegWrite_o, 32'd0);
        cyc();
        chk("ld_memreq_held", MemReq_o, 32'd1);
        MemAck_i = 1'b1;
        MemRdata_i = 32'hDEAD_BEEF;
        cyc();
        chk("ld_memreq_drop", MemReq_o, 32'd0);
        MemAck_i = 1'b0;
        MemRdata_i = 32'h0;
        cyc();
        chk("ld_memdata", MemData_o, 32'hDEAD_BEEF);
        chk("ld_regwrite", RegWrite_o, 32'd1);
        chk("ld_rd", RDaddr_o, 32'd3);
        chk("ld_stall_cycles", stall_cnt, 32'd3);

        // Store with an immediate ack; read data must not be captured
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0204, 32'h1234_5678, 5'd0);
        cyc();
        chk("st_we", MemWe_o, 32'd1);
        chk("st_addr", MemAddr_o, 32'h204);
        chk("st_wdata", MemWdata_o, 32'h1234_5678);
        MemAck_i = 1'b1;
        MemRdata_i = 32'hCAFE_F00D;
        cyc();
        chk("st_memreq_drop", MemReq_o, 32'd0);
        cyc();
        chk("st_regwrite", RegWrite_o, 32'd0);
        chk("st_memdata_held", MemData_o, 32'hDEAD_BEEF);
        chk("st_err", Err_o, 32'd0);
        // Ack while IDLE with a non-memop is ignored
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 5'd8);
        cyc();
        chk("idle_ack_memreq", MemReq_o, 32'd0);
        chk("idle_ack_memdata", MemData_o, 32'hDEAD_BEEF);
        MemAck_i = 1'b0;

        // Misaligned load
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd4);
        #1;
        chk("mis_stall", Stall_o, 32'd0);
        cyc();
        chk("mis_memreq", MemReq_o, 32'd0);
        chk("mis_err", Err_o, 32'd1);
        chk("mis_regwrite", RegWrite_o, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 5'd7);
        cyc();
        chk("mis_err_pulse", Err_o, 32'd0);
        chk("mis_next_alu", ALUResult_o, 32'h44);

        // Timeout: no ack ever
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd9);
        cyc();
        req_cycles = 0;
        for (int i = 0; i < 40 && MemReq_o === 1'b1; i++) begin
            req_cycles++;
            cyc();
        end
        chk("to_req_cycles", req_cycles, 32'd16);
        chk("to_memreq", MemReq_o, 32'd0);
        chk("to_err_early", Err_o, 32'd0);
        cyc();
        chk("to_err", Err_o, 32'd1);
        chk("to_regwrite", RegWrite_o, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0055, 32'h0, 5'd10);
        cyc();
        chk("to_err_pulse", Err_o, 32'd0);
        chk("to_idle_alu", ALUResult_o, 32'h55);

        // Ack on the same cycle as the timeout wins
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 5'd4);
        cyc();
        for (int i = 0; i < 15; i++) cyc();
        chk("race_memreq", MemReq_o, 32'd1);
        MemAck_i = 1'b1;
        MemRdata_i = 32'h0BAD_F00D;
        cyc();
        MemAck_i = 1'b0;
        cyc();
        chk("race_err", Err_o, 32'd0);
        chk("race_regwrite", RegWrite_o, 32'd1);
        chk("race_memdata", MemData_o, 32'h0BAD_F00D);

        // Back-to-back loads, no idle gap
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 5'd11);
        stall_cnt = 0;
        cyc();
        MemAck_i = 1'b1;
        MemRdata_i = 32'h0000_0001;
        cyc();
        MemAck_i = 1'b0;
        cyc();
        chk("b2b_first_data", MemData_o, 32'h1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0504, 32'h0, 5'd12);
        cyc();
        chk("b2b_second_req", MemReq_o, 32'd1);
        chk("b2b_second_addr", MemAddr_o, 32'h504);
        MemAck_i = 1'b1;
        MemRdata_i = 32'h0000_0002;
        cyc();
        MemAck_i = 1'b0;
        cyc();
        chk("b2b_second_data", MemData_o, 32'h2);
        chk("b2b_stall_cycles", stall_cnt, 32'd4);

        // Reset in the middle of REQ
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 5'd6);
        cyc();
        chk("mr_memreq_before", MemReq_o, 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        chk("mr_memreq", MemReq_o, 32'd0);
        chk("mr_stall", Stall_o, 32'd0);
        chk("mr_memdata", MemData_o, 32'd0);
        cyc();
        rst_i = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 5'd2);
        MemAck_i = 1'b1;
        MemRdata_i = 32'h5555_5555;
        cyc();
        MemAck_i = 1'b0;
        chk("mr_ack_memreq", MemReq_o, 32'd0);
        chk("mr_ack_memdata", MemData_o, 32'd0);
        chk("mr_ack_err", Err_o, 32'd0);
        chk("mr_idle_regwrite", RegWrite_o, 32'd1);
        chk("mr_idle_alu", ALUResult_o, 32'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk_i (input, 1, rising-edge clock) and rst_i (input, 1, asynchronous active-low reset).
REQ-002 The EX/MEM-side inputs SHALL be: RegWrite_i, MemtoReg_i, MemRead_i and MemWrite_i (input, 1 each, control bits); ALUResult_i (input, 32, address or result); RS2data_i (input, 32, store data); RDaddr_i (input, 5, destination register).
REQ-003 The data-memory ports SHALL be: MemReq_o (output, 1, request); MemWe_o (output, 1, write enable); MemAddr_o (output, 32, address); MemWdata_o (output, 32, write data); MemAck_i (input, 1, one-cycle completion); MemRdata_i (input, 32, read data, valid with MemAck_i).
REQ-004 The MEM/WB-side outputs SHALL be: RegWrite_o, MemtoReg_o (output, 1 each); ALUResult_o, MemData_o (output, 32 each); RDaddr_o (output, 5).
REQ-005 The status outputs SHALL be: Stall_o (output, 1, freeze upstream stages) and Err_o (output, 1, one-cycle error pulse).
REQ-006 The parameter TIMEOUT SHALL default to 16 and SHALL set the maximum number of cycles spent in REQ before abort.

Function
REQ-007 A memory op (memop) SHALL be MemRead_i|MemWrite_i; if both bits are set, the op SHALL be treated as a write.
REQ-008 The FSM SHALL have the states IDLE, REQ and DONE.
REQ-009 IDLE, non-memop: Stall_o=0, and the MEM/WB registers SHALL load the inputs on the next edge, with MemData_o unchanged (latency 1).
REQ-010 IDLE, aligned memop (ALUResult_i[1:0]==0): Stall_o=1, and the next edge SHALL set MemReq_o=1, latch MemWe_o/MemAddr_o/MemWdata_o, clear the timeout counter and enter REQ.
REQ-011 IDLE, misaligned memop: there SHALL be no request and Stall_o=0; the next edge SHALL load a bubble into MEM/WB (RegWrite_o=0) and pulse Err_o=1 for one cycle.
REQ-012 REQ: Stall_o=1 and MemReq_o/MemWe_o/MemAddr_o/MemWdata_o SHALL be held stable until MemAck_i.
REQ-013 REQ, MemAck_i=1: the next edge SHALL capture MemRdata_i (reads only) into an internal buffer, set MemReq_o=0 and enter DONE.
REQ-014 REQ, no ack when the counter reaches TIMEOUT-1: the next edge SHALL set MemReq_o=0, mark the op aborted and enter DONE.
REQ-015 DONE: Stall_o=0; the next edge SHALL load MEM/WB from the inputs, with MemData_o=buffer, and return to IDLE.
REQ-016 DONE, aborted op: the MEM/WB load SHALL be a bubble (RegWrite_o=0) and Err_o SHALL pulse for one cycle.
REQ-017 While Stall_o=1, MEM/WB SHALL load a bubble each edge: RegWrite_o=0, MemtoReg_o=0, other fields don't-care-but-deterministic (held).
REQ-018 Upstream SHALL hold the EX/MEM inputs stable while Stall_o=1; the block SHALL NOT re-sample the request fields during REQ.
REQ-019 A MemAck_i seen in IDLE or DONE SHALL be ignored.
REQ-020 A MemAck_i arriving on the same cycle as the timeout SHALL win: the op completes normally with no error.
REQ-021 Back-to-back memops SHALL cost 3 cycles each (IDLE to REQ to DONE, with 1-cycle ack), with no idle gap.
REQ-022 The timeout counter SHALL be 5 bits wide and saturating, and SHALL count only in REQ.

Reset
REQ-023 With rst_i=0, the FSM SHALL go to IDLE and all outputs, the counter and the buffer SHALL be 0, immediately and independent of clk_i.
REQ-024 A reset during REQ SHALL drop MemReq_o in the same cycle, and a later MemAck_i SHALL be ignored.
REQ-025 After rst_i rises, the first edge SHALL behave as IDLE.

Verification
REQ-026 Non-memop: RegWrite_i=1, ALUResult_i=0x0000_0010, RDaddr_i=5 -> after 1 edge, RegWrite_o=1, ALUResult_o=0x10, RDaddr_o=5, Stall_o=0, MemReq_o=0.
REQ-027 Load: MemRead_i=1, ALUResult_i=0x100, RDaddr_i=3, with ack 2 cycles after MemReq_o and MemRdata_i=0xDEADBEEF -> MemAddr_o=0x100 and MemWe_o=0; Stall_o high for 3 cycles; then MemData_o=0xDEADBEEF with RegWrite_o=1 and RDaddr_o=3.
REQ-028 Store: MemWrite_i=1, ALUResult_i=0x204, RS2data_i=0x12345678 -> MemWe_o=1, MemAddr_o=0x204, MemWdata_o=0x12345678; after ack, RegWrite_o follows RegWrite_i=0.
REQ-029 Misaligned: MemRead_i=1, ALUResult_i=0x102 -> MemReq_o stays 0, Err_o pulses 1 cycle, RegWrite_o=0.
REQ-030 Timeout: load with MemAck_i never asserted -> MemReq_o drops after 16 cycles in REQ, Err_o pulses, RegWrite_o=0, and the FSM returns to IDLE.
REQ-031 Reset mid-REQ: drive rst_i=0 while MemReq_o=1 -> MemReq_o=0 and Stall_o=0 asynchronously; a MemAck_i applied after reset release has no effect.
